// File: rtl/alu_seq.sv
// alu_seq: registered add/sub/mul/div on unsigned WIDTH-bit operands.
// Results are 2*WIDTH bits wide. valid/ready handshakes on both sides.
// Division uses an iterative restoring divider and returns the quotient in
// f[WIDTH-1:0] and the remainder in f[2*WIDTH-1:WIDTH].
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   f,
    output logic                 div_zero,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        DIV
    } state_t;

    state_t               state, state_n;
    logic                 out_valid_n;
    logic [2*WIDTH-1:0]   f_n;
    logic                 div_zero_n;
    logic [WIDTH-1:0]     divisor, divisor_n;
    logic [WIDTH-1:0]     quot, quot_n;
    logic [WIDTH-1:0]     rem, rem_n;
    logic [CW-1:0]        count, count_n;

    logic [WIDTH:0]       rem_shift;
    logic [WIDTH-1:0]     rem_diff;
    logic                 rem_ge;
    logic [WIDTH-1:0]     quot_step;
    logic [WIDTH-1:0]     rem_step;

    logic [2*WIDTH-1:0]   a_ext, b_ext;
    logic                 accept, consume;

    assign a_ext    = {{WIDTH{1'b0}}, a};
    assign b_ext    = {{WIDTH{1'b0}}, b};
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign busy     = (state == DIV);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    // The remainder is always below the divisor, so the difference fits in WIDTH bits.
    always_comb begin
        rem_shift = {rem, quot[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, divisor});
        rem_diff  = rem_shift[WIDTH-1:0] - divisor;
        quot_step = {quot[WIDTH-2:0], rem_ge};
        rem_step  = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
    end

    // Next-state, result and divider-register update.
    always_comb begin
        state_n     = state;
        out_valid_n = out_valid;
        f_n         = f;
        div_zero_n  = div_zero;
        divisor_n   = divisor;
        quot_n      = quot;
        rem_n       = rem;
        count_n     = count;

        if (consume) begin
            out_valid_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    case (sel)
                        2'b00: begin
                            f_n         = a_ext + b_ext;
                            div_zero_n  = 1'b0;
                            out_valid_n = 1'b1;
                        end
                        2'b01: begin
                            f_n         = a_ext - b_ext;
                            div_zero_n  = 1'b0;
                            out_valid_n = 1'b1;
                        end
                        2'b10: begin
                            f_n         = a_ext * b_ext;
                            div_zero_n  = 1'b0;
                            out_valid_n = 1'b1;
                        end
                        default: begin
                            if (b == '0) begin
                                f_n         = '0;
                                div_zero_n  = 1'b1;
                                out_valid_n = 1'b1;
                            end else begin
                                divisor_n = b;
                                quot_n    = a;
                                rem_n     = '0;
                                count_n   = CW'(WIDTH);
                                state_n   = DIV;
                            end
                        end
                    endcase
                end
            end
            DIV: begin
                quot_n  = quot_step;
                rem_n   = rem_step;
                count_n = count - CW'(1);
                if (count == CW'(1)) begin
                    f_n         = {rem_step, quot_step};
                    div_zero_n  = 1'b0;
                    out_valid_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Result and divider registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            f         <= '0;
            div_zero  <= 1'b0;
            divisor   <= '0;
            quot      <= '0;
            rem       <= '0;
            count     <= '0;
        end else begin
            out_valid <= out_valid_n;
            f         <= f_n;
            div_zero  <= div_zero_n;
            divisor   <= divisor_n;
            quot      <= quot_n;
            rem       <= rem_n;
            count     <= count_n;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: behavioural model for the WIDTH=4 instance checked on
// every falling edge, plus directed literal checks (including a WIDTH=8 divide).
module tb_alu_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] f;
    logic       div_zero;
    logic       busy;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [1:0]  sel8;
    logic        out_valid8;
    logic        out_ready8;
    logic [15:0] f8;
    logic        div_zero8;
    logic        busy8;

    int checks;
    int failures;

    alu_seq #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .sel       (sel8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .f         (f8),
        .div_zero  (div_zero8),
        .busy      (busy8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pending divide is a countdown plus its precomputed quotient/remainder.
    logic       m_valid;
    logic [7:0] m_f;
    logic       m_dz;
    int         m_left;
    logic [7:0] m_res;
    logic       m_last_acc;
    logic       m_in_ready;

    assign m_in_ready = (m_left == 0) && (!m_valid || out_ready);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_f        <= 8'h00;
            m_dz       <= 1'b0;
            m_left     <= 0;
            m_res      <= 8'h00;
            m_last_acc <= 1'b0;
        end else begin
            m_last_acc <= in_valid && m_in_ready;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_valid <= 1'b1;
                    m_f     <= m_res;
                    m_dz    <= 1'b0;
                end
            end else begin
                if (m_valid && out_ready) m_valid <= 1'b0;
                if (in_valid && m_in_ready) begin
                    case (sel)
                        2'd0: begin m_f <= {4'h0, a} + {4'h0, b}; m_dz <= 1'b0; m_valid <= 1'b1; end
                        2'd1: begin m_f <= {4'h0, a} - {4'h0, b}; m_dz <= 1'b0; m_valid <= 1'b1; end
                        2'd2: begin m_f <= {4'h0, a} * {4'h0, b}; m_dz <= 1'b0; m_valid <= 1'b1; end
                        default: begin
                            if (b == 4'd0) begin
                                m_f <= 8'h00; m_dz <= 1'b1; m_valid <= 1'b1;
                            end else begin
                                m_res  <= {4'(a % b), 4'(a / b)};
                                m_left <= 4;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
            check("cyc_in_ready", 32'(in_ready), 32'(m_in_ready));
            check("cyc_busy", 32'(busy), 32'(m_left != 0));
            check("cyc_f", 32'(f), 32'(m_f));
            check("cyc_div_zero", 32'(div_zero), 32'(m_dz));
        end
    end

    task automatic issue(input logic [3:0] ta, input logic [3:0] tb, input logic [1:0] ts);
        bit acc;
        acc = 1'b0;
        a = ta;
        b = tb;
        sel = ts;
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (m_last_acc) begin
                acc = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout actual=not_accepted required=accepted at %0t", $time);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clk = 1'b0;
        rst = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sel = '0;
        out_ready = 1'b1;
        in_valid8 = 1'b0;
        a8 = '0;
        b8 = '0;
        sel8 = '0;
        out_ready8 = 1'b1;

        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_f", 32'(f), 32'h0);
        check("rst_div_zero", 32'(div_zero), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_f8", 32'(f8), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // add with carry into bit WIDTH
        issue(4'd9, 4'd7, 2'd0);
        check("add_f", 32'(f), 32'h10);
        check("add_model_f", 32'(m_f), 32'h10);
        check("add_valid", 32'(out_valid), 32'h1);
        check("add_dz", 32'(div_zero), 32'h0);

        // sub then mul back-to-back
        issue(4'd3, 4'd5, 2'd1);
        check("sub_f", 32'(f), 32'hFE);
        check("sub_in_ready", 32'(in_ready), 32'h1);
        issue(4'd15, 4'd15, 2'd2);
        check("mul_f", 32'(f), 32'hE1);
        check("mul_valid", 32'(out_valid), 32'h1);
        @(posedge clk);
        #1;
        check("mul_consumed", 32'(out_valid), 32'h0);

        // 13/4 with WIDTH-cycle latency
        issue(4'd13, 4'd4, 2'd3);
        check("div_busy", 32'(busy), 32'h1);
        check("div_in_ready", 32'(in_ready), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check("div_lat_valid", 32'(out_valid), 32'(i == 4));
            check("div_lat_busy", 32'(busy), 32'(i != 4));
        end
        check("div_f", 32'(f), 32'h13);
        check("div_model_f", 32'(m_f), 32'h13);
        check("div_dz", 32'(div_zero), 32'h0);

        // WIDTH=8: 200/7 = 28 rem 4
        a8 = 8'd200;
        b8 = 8'd7;
        sel8 = 2'd3;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        check("div8_busy", 32'(busy8), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            check("div8_lat_valid", 32'(out_valid8), 32'(i == 8));
        end
        check("div8_f", 32'(f8), 32'h041C);
        check("div8_dz", 32'(div_zero8), 32'h0);
        check("div8_in_ready", 32'(in_ready8), 32'h1);

        // divide by zero, then add clears div_zero
        issue(4'd9, 4'd0, 2'd3);
        check("dz_valid", 32'(out_valid), 32'h1);
        check("dz_f", 32'(f), 32'h0);
        check("dz_flag", 32'(div_zero), 32'h1);
        issue(4'd2, 4'd3, 2'd0);
        check("dz_clear", 32'(div_zero), 32'h0);
        check("dz_add_f", 32'(f), 32'h05);

        // backpressure with a waiting request, released into a same-edge consume+accept
        @(posedge clk);
        #1;
        issue(4'd4, 4'd5, 2'd0);
        out_ready = 1'b0;
        a = 4'd1;
        b = 4'd1;
        sel = 2'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(out_valid), 32'h1);
            check("bp_f", 32'(f), 32'h09);
            check("bp_in_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_b2b_valid", 32'(out_valid), 32'h1);
        check("bp_b2b_f", 32'(f), 32'h02);
        @(posedge clk);
        #1;
        check("bp_drained", 32'(out_valid), 32'h0);

        // reset in the middle of a divide
        issue(4'd13, 4'd4, 2'd3);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_f", 32'(f), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        issue(4'd1, 4'd1, 2'd0);
        check("post_rst_f", 32'(f), 32'h02);
        check("post_rst_valid", 32'(out_valid), 32'h1);
        check("post_rst_busy", 32'(busy), 32'h0);
        repeat (6) @(posedge clk);
        #1;
        check("no_stale_valid", 32'(out_valid), 32'h0);
        check("no_stale_f", 32'(f), 32'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
